axi4_lite_rr_arbiter: RTL and testbench
=======================================

# axi4_lite_rr_arbiter

Round-robin arbiter and transaction sequencer for the shared AXI4-Lite slave port behind the simple AXI4-Lite mux. It watches per-master AW/AR requests, grants one master at a time, and holds the grant until the full transaction completes (B or R handshake) or times out. It drives the mux select plus a grant-valid qualifier, so direction never changes mid-transaction. The downstream mux gates the slave-side valids with `grant_valid_o`.

## Interface
- `MASTERS_AMOUNT`, 2: number of requesting masters, at least 2.
- `DIR_WIDTH`, `$clog2(MASTERS_AMOUNT)`: select width.
- `TIMEOUT_CYCLES`, 1024: grant watchdog in cycles; 0 disables the watchdog.
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `awvalid_i`  in  MASTERS_AMOUNT  per-master AW request.
- `arvalid_i`  in  MASTERS_AMOUNT  per-master AR request.
- `s_bvalid_i`, `s_bready_i`  in  1 each  slave-side B handshake.
- `s_rvalid_i`, `s_rready_i`  in  1 each  slave-side R handshake.
- `dir_o`  out  DIR_WIDTH  granted master index, feeds the mux `dir_i`.
- `grant_valid_o`  out  1  a grant is active.
- `grant_wr_o`  out  1  the active grant is a write; 0 means read.
- `timeout_o`  out  1  one-cycle pulse when the watchdog releases a grant.

## Operation
- FSM states: IDLE, WRITE, READ.
- **IDLE:**
  - Request vector `req[i] = awvalid_i[i] | arvalid_i[i]`.
  - When any bit is set, pick the first set bit searching upward from `last + 1` modulo MASTERS_AMOUNT, where `last` is the previously granted index.
  - Register the choice into `dir_o` and `last`.
- **Write vs read selection:**
  - Winner has only AW asserted: go to WRITE.
  - Winner has only AR asserted: go to READ.
  - Winner has both: take the type opposite to the global `prev_wr` flag, then update `prev_wr` to the type taken.
- **WRITE:** exit to IDLE on `s_bvalid_i & s_bready_i`.
- **READ:** exit to IDLE on `s_rvalid_i & s_rready_i`.
- **Watchdog:**
  - Counter clears on grant and increments each cycle in WRITE or READ.
  - When it reaches TIMEOUT_CYCLES (and that value is nonzero), return to IDLE and pulse `timeout_o`.
  - A completion handshake in the same cycle takes priority: no timeout pulse.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`, saturating, so no wrap.
- **`dir_o`:** holds its value in IDLE; it changes only on a new grant.
- **Request-drop rule:** requests that drop while in IDLE before being granted are simply not served.
- **Index wrap-around:** the `last + 1` search wraps from MASTERS_AMOUNT-1 to 0.
- **Reset:**
  - Values: state IDLE, `dir_o` = 0, `last` = MASTERS_AMOUNT-1 (so master 0 is first), `prev_wr` = 1 (so reads win the first tie), `grant_valid_o` = 0, `grant_wr_o` = 0, `timeout_o` = 0, counter 0.
  - Reset asserted mid-transaction returns to reset values immediately. The slave-side transaction is abandoned.

## Timing
- All outputs are registered.
- **Grant latency:** request visible in cycle N in IDLE gives `grant_valid_o`/`dir_o`/`grant_wr_o` valid in cycle N+1.
- **Release:** completion handshake in cycle M gives `grant_valid_o` = 0 in cycle M+1. The earliest next grant is M+2, so there is one mandatory idle cycle between transactions.
- **Timeout:** the grant is released in the cycle after the counter reaches TIMEOUT_CYCLES; `timeout_o` is high for exactly that cycle.
- **Ignored signals:** completion handshakes seen in IDLE, and the opposite-type handshake (e.g. R during WRITE), are ignored.

## Structure
- Package `axi4_lite_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, WRITE, READ);
  - a `DIR_W` helper function.
- Sub-module `rr_priority_picker`: combinational; inputs are the request vector and `last`; outputs are the index and a found flag. It is reusable by other codebase arbiters.

## Test plan
- **Single master:** `awvalid_i` = 2'b01 with B handshake 3 cycles after grant → `dir_o` = 0, `grant_wr_o` = 1; `grant_valid_o` high 4 cycles then drops.
- **Fairness:** both masters request reads continuously, each R handshake 2 cycles after grant → grants alternate 0, 1, 0, 1, with one idle cycle between grants.
- **Tie:** master 1 asserts AW and AR together from reset → first grant READ, next grant WRITE, third grant READ.
- **Timeout:** TIMEOUT_CYCLES = 8, grant with no B → `timeout_o` pulses 8 cycles after grant; `grant_valid_o` drops the same cycle; next request is granted the following cycle.
- **Reset mid-transaction:** `rst_n_i` low during WRITE → all outputs at reset values asynchronously; master 0 is granted first after release.
- **Ignored handshake:** R handshake during a WRITE grant → no release; only B releases.

Source files
------------

// File: rtl/axi4_lite_arb_pkg.sv
// Shared types and helpers for the AXI4-Lite slave-port arbiters.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package axi4_lite_arb_pkg;

    // Arbiter sequencer states: no grant, or a write/read transaction in flight.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } arb_state_t;

    // Width of an index into n requesters. This never returns 0, so a
    // degenerate single-requester build still gets a legal vector width.
    function automatic int DIR_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request bit searching upward from last+1, wrapping.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides whether to consume the pick.
// Ports:
//   req   - request vector, one bit per requester
//   last  - index granted most recently (the search starts just above it)
//   idx   - chosen index, valid only when found is high
//   found - at least one request bit is set
module rr_priority_picker
    import axi4_lite_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = DIR_W(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from the farthest back to the nearest so that the
    // nearest requester above `last` is the final (winning) assignment.
    // Offset NUM_REQ lands on `last` itself, so a lone requester that was
    // granted last time is still picked.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(last) + i) % NUM_REQ);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_rr_arbiter.sv
// Round-robin grant sequencer for the shared AXI4-Lite slave port behind the mux.
// Latency: grant registered 1 cycle after a request is seen in IDLE; release 1 cycle after B/R handshake.
// Backpressure: grant is held until the matching B/R handshake or the watchdog fires; others wait.
// Ports:
//   clk_i, rst_n_i           - clock, asynchronous active-low reset
//   awvalid_i, arvalid_i     - per-master write/read requests
//   s_bvalid_i, s_bready_i   - slave-side write-response handshake
//   s_rvalid_i, s_rready_i   - slave-side read-data handshake
//   dir_o                    - granted master index for the mux select
//   grant_valid_o            - a grant is active (mux gates slave valids with it)
//   grant_wr_o               - active grant is a write (0 = read)
//   timeout_o                - one-cycle pulse when the watchdog drops a grant
module axi4_lite_rr_arbiter
    import axi4_lite_arb_pkg::*;
#(
    parameter int MASTERS_AMOUNT = 2,
    parameter int DIR_WIDTH      = DIR_W(MASTERS_AMOUNT),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [MASTERS_AMOUNT-1:0] awvalid_i,
    input  logic [MASTERS_AMOUNT-1:0] arvalid_i,
    input  logic                      s_bvalid_i,
    input  logic                      s_bready_i,
    input  logic                      s_rvalid_i,
    input  logic                      s_rready_i,
    output logic [DIR_WIDTH-1:0]      dir_o,
    output logic                      grant_valid_o,
    output logic                      grant_wr_o,
    output logic                      timeout_o
);

    // Counter is sized to hold TIMEOUT_CYCLES itself; a disabled watchdog
    // still gets a 1-bit counter so no zero-width vector appears.
    localparam int               CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t           state_q, state_d;
    logic [DIR_WIDTH-1:0] dir_q, dir_d;
    logic [DIR_WIDTH-1:0] last_q, last_d;
    logic                 prev_wr_q, prev_wr_d;
    logic                 gnt_vld_q;
    logic                 gnt_wr_q, gnt_wr_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [MASTERS_AMOUNT-1:0] req;
    logic [DIR_WIDTH-1:0]      pick_idx;
    logic                      pick_found;
    logic [CNT_W-1:0]          cnt_inc;
    logic                      wd_hit;
    logic                      take_wr;

    assign req = awvalid_i | arvalid_i;

    rr_priority_picker #(
        .NUM_REQ (MASTERS_AMOUNT),
        .IDX_W   (DIR_WIDTH)
    ) u_picker (
        .req   (req),
        .last  (last_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Saturating increment; the watchdog fires on the cycle whose increment
    // brings the count to TIMEOUT_CYCLES, so the grant is seen for exactly
    // TIMEOUT_CYCLES cycles before release.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign wd_hit  = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_VAL);

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        last_d    = last_q;
        prev_wr_d = prev_wr_q;
        gnt_wr_d  = gnt_wr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        take_wr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    dir_d  = pick_idx;
                    last_d = pick_idx;
                    cnt_d  = '0;
                    // A master offering both directions alternates against
                    // the global history so neither type can starve.
                    if (awvalid_i[pick_idx] && arvalid_i[pick_idx]) begin
                        take_wr   = ~prev_wr_q;
                        prev_wr_d = take_wr;
                    end else begin
                        take_wr = awvalid_i[pick_idx];
                    end
                    gnt_wr_d = take_wr;
                    state_d  = take_wr ? WRITE : READ;
                end
            end

            WRITE: begin
                cnt_d = cnt_inc;
                if (s_bvalid_i && s_bready_i) begin
                    state_d = IDLE;
                end else if (wd_hit) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end

            READ: begin
                cnt_d = cnt_inc;
                if (s_rvalid_i && s_rready_i) begin
                    state_d = IDLE;
                end else if (wd_hit) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            dir_q     <= '0;
            last_q    <= DIR_WIDTH'(MASTERS_AMOUNT - 1);
            prev_wr_q <= 1'b1;
            gnt_vld_q <= 1'b0;
            gnt_wr_q  <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            last_q    <= last_d;
            prev_wr_q <= prev_wr_d;
            gnt_vld_q <= (state_d != IDLE);
            gnt_wr_q  <= gnt_wr_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dir_o         = dir_q;
    assign grant_valid_o = gnt_vld_q;
    assign grant_wr_o    = gnt_wr_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_axi4_lite_rr_arbiter.sv
// Directed bench for the AXI4-Lite round-robin arbiter.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_axi4_lite_rr_arbiter;

    localparam int M  = 2;
    localparam int DW = 1;

    logic          clk_i;
    logic          rst_n_i;
    logic [M-1:0]  awvalid_i;
    logic [M-1:0]  arvalid_i;
    logic          s_bvalid_i;
    logic          s_bready_i;
    logic          s_rvalid_i;
    logic          s_rready_i;
    logic [DW-1:0] dir_o;
    logic          grant_valid_o;
    logic          grant_wr_o;
    logic          timeout_o;

    int n_checks = 0;
    int n_fails  = 0;

    axi4_lite_rr_arbiter #(
        .MASTERS_AMOUNT (M),
        .DIR_WIDTH      (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .awvalid_i     (awvalid_i),
        .arvalid_i     (arvalid_i),
        .s_bvalid_i    (s_bvalid_i),
        .s_bready_i    (s_bready_i),
        .s_rvalid_i    (s_rvalid_i),
        .s_rready_i    (s_rready_i),
        .dir_o         (dir_o),
        .grant_valid_o (grant_valid_o),
        .grant_wr_o    (grant_wr_o),
        .timeout_o     (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land just after the edge: outputs shown are the
    // values for the new cycle, inputs driven now are sampled at the next edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_inputs();
        awvalid_i  = '0;
        arvalid_i  = '0;
        s_bvalid_i = 1'b0;
        s_bready_i = 1'b0;
        s_rvalid_i = 1'b0;
        s_rready_i = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        clr_inputs();
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b1;
        step();
    endtask

    logic tie_wr [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        rst_n_i = 1'b0;
        clr_inputs();
        #23;
        // Reset values while reset is still asserted.
        chk_val("rst_gv",  grant_valid_o, 0);
        chk_val("rst_dir", dir_o,         0);
        chk_val("rst_wr",  grant_wr_o,    0);
        chk_val("rst_to",  timeout_o,     0);
        rst_n_i = 1'b1;
        step();

        // ---- single master write, B three cycles after grant ----
        awvalid_i = 2'b01;
        step();
        chk_val("single_gv",  grant_valid_o, 1);
        chk_val("single_dir", dir_o,         0);
        chk_val("single_wr",  grant_wr_o,    1);
        awvalid_i = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_val($sformatf("single_hold%0d", k), grant_valid_o, 1);
        end
        s_bvalid_i = 1'b1;
        s_bready_i = 1'b1;
        step();
        s_bvalid_i = 1'b0;
        s_bready_i = 1'b0;
        chk_val("single_rel", grant_valid_o, 0);
        chk_val("single_dir_hold", dir_o, 0);

        // ---- fairness: both masters read continuously ----
        do_reset();
        arvalid_i = 2'b11;
        for (int g = 0; g < 4; g++) begin
            step();
            chk_val($sformatf("fair_gv%0d", g),  grant_valid_o, 1);
            chk_val($sformatf("fair_dir%0d", g), dir_o,         g % 2);
            chk_val($sformatf("fair_wr%0d", g),  grant_wr_o,    0);
            step();
            step();
            chk_val($sformatf("fair_hold%0d", g), grant_valid_o, 1);
            s_rvalid_i = 1'b1;
            s_rready_i = 1'b1;
            step();
            s_rvalid_i = 1'b0;
            s_rready_i = 1'b0;
            chk_val($sformatf("fair_idle%0d", g), grant_valid_o, 0);
        end
        arvalid_i = 2'b00;

        // ---- tie: master 1 offers AW and AR together ----
        do_reset();
        awvalid_i = 2'b10;
        arvalid_i = 2'b10;
        for (int t = 0; t < 3; t++) begin
            step();
            chk_val($sformatf("tie_gv%0d", t),  grant_valid_o, 1);
            chk_val($sformatf("tie_dir%0d", t), dir_o,         1);
            chk_val($sformatf("tie_wr%0d", t),  grant_wr_o,    tie_wr[t]);
            if (tie_wr[t]) begin
                s_bvalid_i = 1'b1;
                s_bready_i = 1'b1;
            end else begin
                s_rvalid_i = 1'b1;
                s_rready_i = 1'b1;
            end
            step();
            clr_inputs();
            awvalid_i = 2'b10;
            arvalid_i = 2'b10;
            chk_val($sformatf("tie_rel%0d", t), grant_valid_o, 0);
        end
        clr_inputs();

        // ---- opposite-type handshake ignored during WRITE ----
        do_reset();
        awvalid_i = 2'b01;
        step();
        chk_val("ign_wr", grant_wr_o, 1);
        awvalid_i  = 2'b00;
        s_rvalid_i = 1'b1;
        s_rready_i = 1'b1;
        step();
        s_rvalid_i = 1'b0;
        s_rready_i = 1'b0;
        chk_val("ign_r_hold", grant_valid_o, 1);
        s_bvalid_i = 1'b1;
        s_bready_i = 1'b1;
        step();
        s_bvalid_i = 1'b0;
        s_bready_i = 1'b0;
        chk_val("ign_b_rel", grant_valid_o, 0);

        // ---- watchdog timeout, then completion beating the watchdog ----
        do_reset();
        awvalid_i = 2'b01;
        step();
        chk_val("to_gv", grant_valid_o, 1);
        awvalid_i = 2'b00;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk_val($sformatf("to_hold%0d", k), grant_valid_o, 1);
            chk_val($sformatf("to_quiet%0d", k), timeout_o, 0);
        end
        step();
        chk_val("to_pulse", timeout_o,     1);
        chk_val("to_rel",   grant_valid_o, 0);
        awvalid_i = 2'b10;
        step();
        chk_val("to_pulse_end", timeout_o,     0);
        chk_val("to_next_gv",   grant_valid_o, 1);
        chk_val("to_next_dir",  dir_o,         1);
        awvalid_i = 2'b00;
        for (int k = 1; k <= 7; k++) step();
        s_bvalid_i = 1'b1;
        s_bready_i = 1'b1;
        step();
        s_bvalid_i = 1'b0;
        s_bready_i = 1'b0;
        chk_val("to_prio_rel",   grant_valid_o, 0);
        chk_val("to_prio_nopls", timeout_o,     0);

        // ---- asynchronous reset mid-transaction ----
        do_reset();
        awvalid_i = 2'b01;
        step();
        awvalid_i = 2'b00;
        s_bvalid_i = 1'b1;
        s_bready_i = 1'b1;
        step();
        s_bvalid_i = 1'b0;
        s_bready_i = 1'b0;
        awvalid_i = 2'b11;
        step();
        chk_val("mid_pre_dir", dir_o,      1);
        chk_val("mid_pre_wr",  grant_wr_o, 1);
        step();
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_val("mid_rst_gv",  grant_valid_o, 0);
        chk_val("mid_rst_dir", dir_o,         0);
        chk_val("mid_rst_wr",  grant_wr_o,    0);
        chk_val("mid_rst_to",  timeout_o,     0);
        #1;
        rst_n_i = 1'b1;
        step();
        chk_val("mid_after_gv",  grant_valid_o, 1);
        chk_val("mid_after_dir", dir_o,         0);
        chk_val("mid_after_wr",  grant_wr_o,    1);
        clr_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
